fifo_push_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/fifo_push_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and sizing helpers for the FIFO push arbiter.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

    // Width of a binary index for n items, never below one bit.
    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: rotate by ptr, priority-encode, unrotate.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    localparam int unsigned IW = id_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    input  logic          en_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW-1:0]  k;
    logic [IW:0]    sum;
    logic           found;

    // Lowest set bit of the rotated request is the winner; map back to absolute index.
    always_comb begin
        dbl   = {req_i, req_i};
        rot   = N'(dbl >> ptr_i);
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && rot[i]) begin
                found = 1'b1;
                k     = IW'(i);
            end
        end
        sum = (IW+1)'(k) + (IW+1)'(ptr_i);
        if (sum >= (IW+1)'(N)) begin
            sum = sum - (IW+1)'(N);
        end
        gnt_idx_o = IW'(sum);
        gnt_o     = '0;
        if (en_i && found) begin
            gnt_o[gnt_idx_o] = 1'b1;
        end
    end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter with flush sequencing in front of a shared FIFO.
module fifo_push_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned FLUSH_CYCLES = 4,
    parameter int unsigned SETTLE       = 2,
    localparam int unsigned IDW = id_width(N_REQ)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_REQ-1:0]       req_valid_i,
    input  logic [N_REQ*WIDTH-1:0] req_data_i,
    output logic [N_REQ-1:0]       req_ready_o,
    output logic [IDW+WIDTH-1:0]   fifo_data_o,
    output logic                   fifo_push_o,
    input  logic                   fifo_full_i,
    input  logic                   fifo_empty_i,
    output logic                   fifo_flush_o,
    input  logic                   flush_req_i,
    output logic                   flush_done_o,
    output logic                   busy_o
);

    localparam int unsigned FCW = id_width(FLUSH_CYCLES);
    localparam int unsigned SCW = id_width(SETTLE + 1);

    arb_state_e       state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [FCW-1:0]   flush_cnt_q, flush_cnt_d;
    logic [SCW-1:0]   settle_q, settle_d;

    logic             arb_en;
    logic [N_REQ-1:0] gnt;
    logic [IDW-1:0]   gnt_idx;
    logic             transfer;
    logic [IDW-1:0]   sel;
    logic [WIDTH-1:0] payload;

    // Grants are only offered in RUN with no flush pending, room in the FIFO and out of reset.
    assign arb_en = (state_q == RUN) && !flush_req_i && !fifo_full_i && !rst_i;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req_i     (req_valid_i),
        .ptr_i     (ptr_q),
        .en_i      (arb_en),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    assign transfer    = |(gnt & req_valid_i);
    assign req_ready_o = gnt;
    assign fifo_push_o = transfer;

    // Present the granted payload, or the one at ptr when idle so the bus stays stable.
    always_comb begin
        sel     = transfer ? gnt_idx : ptr_q;
        payload = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (sel == IDW'(k)) begin
                payload = req_data_i[k*WIDTH +: WIDTH];
            end
        end
    end

    assign fifo_data_o = {sel, payload};

    // State-decoded status outputs.
    assign fifo_flush_o = (state_q == FLUSH);
    assign flush_done_o = (state_q == DONE);
    assign busy_o       = (state_q != RUN);

    // Next-state, pointer and counter logic.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        flush_cnt_d = flush_cnt_q;
        settle_d    = settle_q;
        case (state_q)
            RUN: begin
                if (transfer) begin
                    ptr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
                end
                if (flush_req_i) begin
                    state_d     = FLUSH;
                    flush_cnt_d = '0;
                end
            end
            FLUSH: begin
                if (flush_cnt_q == FCW'(FLUSH_CYCLES - 1)) begin
                    state_d     = DRAIN;
                    flush_cnt_d = '0;
                    settle_d    = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FCW'(1);
                end
            end
            DRAIN: begin
                if (fifo_empty_i) begin
                    settle_d = settle_q + SCW'(1);
                    if (settle_q == SCW'(SETTLE - 1)) begin
                        state_d = DONE;
                    end
                end else begin
                    settle_d = '0;
                end
            end
            DONE: begin
                state_d  = RUN;
                settle_d = '0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, pointer and counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= RUN;
            ptr_q       <= '0;
            flush_cnt_q <= '0;
            settle_q    <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            flush_cnt_q <= flush_cnt_d;
            settle_q    <= settle_d;
        end
    end

endmodule
